// File: rtl/regfile_sb.sv
// regfile_sb: register file with write bypass, pending-write scoreboard and hardware clear sequencer
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear_req,
  output logic                  ready,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_addr,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      busy
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t            r_state, w_nxt;
  logic [AW-1:0]     r_clr_ptr;
  logic [NREGS-1:0]  r_pend;
  logic [XLEN-1:0]   r_regs [NREGS];
  logic              w_run, w_wr_ok, w_iss_ok;
  function automatic logic f_legal(input logic [AW-1:0] a);
    return ({1'b0, a} < (AW+1)'(NREGS)) && !(ZERO_REG && a == '0);
  endfunction
  assign w_run    = r_state == RUN;
  assign ready    = w_run;
  assign w_wr_ok  = w_run && !clear_req && wr_en && f_legal(wr_addr);
  assign w_iss_ok = w_run && !clear_req && iss_en && f_legal(iss_addr);
  always_comb
    w_nxt = (r_state == CLEAR) ? ((r_clr_ptr == AW'(NREGS-1)) ? RUN : CLEAR)
                               : (clear_req ? CLEAR : RUN);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= CLEAR;
      r_clr_ptr <= '0;
      r_pend    <= '0;
    end else begin
      r_state   <= w_nxt;
      r_clr_ptr <= (r_state == CLEAR && w_nxt == CLEAR) ? r_clr_ptr + 1'b1 : '0;
      if (!w_run || clear_req) r_pend <= '0;
      else begin
        if (w_wr_ok) r_pend[wr_addr] <= 1'b0;
        if (w_iss_ok) r_pend[iss_addr] <= 1'b1;
      end
    end
  end
  // storage carries no reset so it can map onto RAM; the clear sequencer zeroes it
  always_ff @(posedge clk) begin
    if (!w_run) r_regs[r_clr_ptr] <= '0;
    else if (w_wr_ok) r_regs[wr_addr] <= wr_data;
  end
  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [AW-1:0] w_a;
    logic          w_ok, w_byp;
    assign w_a   = rd_addr[g*AW +: AW];
    assign w_ok  = w_run && f_legal(w_a);
    assign w_byp = wr_en && wr_addr == w_a;
    assign rd_data[g*XLEN +: XLEN] = !w_ok ? '0 : (w_byp ? wr_data : r_regs[w_a]);
    assign busy[g] = w_ok && r_pend[w_a] && !w_byp;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with write-to-read bypass, a per-register pending-write scoreboard, and a hardware clear sequencer. It replaces the fixed 32x32, two-read-port register file in the core's decode/writeback path. Decode issues producers and reads operands through it, and writeback retires results into it. Storage is not reset; it is zeroed by an internal clear FSM so the array can map to RAM.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (2..64)
- NREAD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes and issues
- AW (derived, not overridable), $clog2(NREGS), address width
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- clear_req  in  1  request a full re-clear of storage and scoreboard
- ready  out  1  high when the file is in RUN and usable
- wr_en  in  1  writeback strobe
- wr_addr  in  AW  writeback register
- wr_data  in  XLEN  writeback value
- iss_en  in  1  issue strobe; marks iss_addr pending
- iss_addr  in  AW  destination of the issued instruction
- rd_addr  in  NREAD*AW  packed read addresses; port i uses bits [i*AW +: AW]
- rd_data  out  NREAD*XLEN  packed read data, combinational
- busy  out  NREAD  per-port "operand still pending" flag, combinational

## Operation
- FSM states are CLEAR and RUN.
- Reset assertion forces CLEAR asynchronously, sets clr_ptr=0 and clears all pending bits.
- Storage has no reset.
- In CLEAR, each cycle writes 0 to registers[clr_ptr] and increments clr_ptr.
  - When clr_ptr==NREGS-1 is written, the next state is RUN.
  - Total CLEAR duration is NREGS cycles.
- In CLEAR:
  - wr_en and iss_en are ignored.
  - rd_data is forced to all zeros.
  - busy is forced to 0.
  - clear_req is ignored; the sequence does not restart.
- In RUN, clear_req=1 moves the FSM to CLEAR at the next edge, with clr_ptr=0 and all pending bits cleared.
  - A wr_en or iss_en in that same cycle is discarded.
- Write: in RUN, with wr_en=1 and a legal address, registers[wr_addr] <= wr_data and pending[wr_addr] <= 0.
- Issue: in RUN, with iss_en=1 and a legal address, pending[iss_addr] <= 1.
- Issue and write to the same address in the same cycle: data is written and pending ends at 1. The new producer wins.
- Read port i:
  - If the address is illegal, rd_data=0.
  - Otherwise, if wr_en=1 and wr_addr==rd_addr[i], rd_data=wr_data (bypass).
  - Otherwise rd_data=registers[rd_addr[i]].
- busy[i] = pending[rd_addr[i]] AND NOT (wr_en AND wr_addr==rd_addr[i]), gated to 0 for illegal addresses.
  - A same-cycle issue does not affect busy; the issuing instruction sees the old state.
- Illegal address means:
  - address >= NREGS, or
  - address == 0 when ZERO_REG=1.
- Illegal addresses are never written and never set pending.
- All read ports are independent. Any number of ports may read the same address.

## Timing
- Reset values: ready=0, busy=0, rd_data=0, FSM=CLEAR, clr_ptr=0, pending=0.
- Reset deassertion must be synchronised externally.
- ready rises in the first cycle of RUN, which is NREGS cycles after the first clock edge following reset release.
- ready falls in the cycle after clear_req is sampled.
- Write latency: a value written at edge N is visible through the array from cycle N+1, and through the bypass in cycle N itself.
- Issue-to-busy latency is 1 cycle.
- Writeback clears busy combinationally in the same cycle.
- Reset asserted mid-CLEAR or mid-RUN aborts immediately; the full sequence restarts from clr_ptr=0.

## Test plan
- Reset, then release with NREGS=32: ready=0 for 32 cycles, then 1. After that, all 32 registers read 0 on every port.
- RUN, write x5=0xDEADBEEF while reading x5 on port 0 in the same cycle:
  - rd_data[0]=0xDEADBEEF (bypass).
  - Next cycle, with wr_en=0, port 0 still reads 0xDEADBEEF.
- ZERO_REG=1, write x0=0xFFFFFFFF and issue x0: rd_data=0 and busy=0 for x0 on all ports. Repeat with ZERO_REG=0: x0 reads 0xFFFFFFFF.
- Scoreboard sequence on x7:
  - Issue x7: busy=1 on a port reading x7 from the next cycle.
  - Writeback x7=0x1234: busy=0 in that cycle and rd_data=0x1234.
  - Simultaneous issue+write of x7: busy=1 in the following cycle and data=new value.
- clear_req in RUN with x3=0x55 pending:
  - ready=0 next cycle, and writes/issues are ignored for 32 cycles.
  - Then ready=1, x3 reads 0, busy=0.
  - A clear_req pulse during CLEAR does not extend it.
- NREGS=24 (AW=5):
  - Write to address 30 is ignored. Reads of 30 give 0 and busy=0.
  - reset_n asserted at clr_ptr=10 restarts the clear, and ready rises 24 cycles after release.
